// File: rtl/interrupt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ctrl_pkg
// Description : Shared definitions for the machine-mode interrupt controller.
//               Holds CSR addresses, cause codes, CSR bit positions and FSM
//               state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_ctrl_pkg;

    localparam int          DEF_ADDR_WIDTH   = 32;
    localparam logic [31:0] ZERO             = 32'd0;

    localparam logic [11:0] CSR_MSTATUS      = 12'h300;
    localparam logic [11:0] CSR_MIE          = 12'h304;
    localparam logic [11:0] CSR_MTVEC        = 12'h305;
    localparam logic [11:0] CSR_MEPC         = 12'h341;
    localparam logic [11:0] CSR_MCAUSE       = 12'h342;
    localparam logic [11:0] CSR_MIP          = 12'h344;

    localparam logic [4:0]  CAUSE_MTI        = 5'd7;
    localparam logic [4:0]  CAUSE_MEI_BASE   = 5'd16;

    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam int          MIE_MTIE_BIT     = 7;
    localparam int          MIE_MEIE_BASE    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/interrupt_ctrl_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational priority encoder over the pending-and-enabled
//               interrupt lines. Timer beats external; lowest external wins.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import interrupt_ctrl_pkg::*;
#(
    parameter int NUM_EXT_IRQ = 4
) (
    input  logic                   timer_pend_in,
    input  logic [NUM_EXT_IRQ-1:0] ext_pend_in,
    output logic                   valid_out,
    output logic [4:0]             cause_out
);

    // Scan externals high-to-low so the lowest index is the last to write,
    // then let the timer override everything.
    always_comb begin
        valid_out = 1'b0;
        cause_out = 5'd0;
        for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
            if (ext_pend_in[i]) begin
                valid_out = 1'b1;
                cause_out = CAUSE_MEI_BASE + 5'(i);
            end
        end
        if (timer_pend_in) begin
            valid_out = 1'b1;
            cause_out = CAUSE_MTI;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ctrl
// Description : Machine-mode interrupt controller. Holds mstatus/mie/mip/
//               mtvec/mepc/mcause, takes timer and external interrupts and
//               raises a one-cycle redirect on trap entry or mret.
//               Optional macro INTERRUPT_VECTORED_EN enables vectored mode
//               (mtvec[1:0]==2'b01 -> base + 4*cause).
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NUM_EXT_IRQ = 4
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   timer_irq_in,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq_in,
    input  logic                   stall_in,
    input  logic                   mret_in,
    input  logic [ADDR_WIDTH-1:0]  pc_of_epc_in,
    input  logic                   csr_we_in,
    input  logic [11:0]            csr_addr_in,
    input  logic [ADDR_WIDTH-1:0]  csr_wdata_in,
    output logic [ADDR_WIDTH-1:0]  csr_rdata_out,
    output logic                   interrupt_en_out,
    output logic [ADDR_WIDTH-1:0]  isr_pc_out
);

    state_t                   state_q, state_d;
    logic                     st_mie_q, st_mie_d;
    logic                     st_mpie_q, st_mpie_d;
    logic                     mtie_q, mtie_d;
    logic [NUM_EXT_IRQ-1:0]   meie_q, meie_d;
    logic [ADDR_WIDTH-1:0]    mtvec_q, mtvec_d;
    logic [ADDR_WIDTH-1:0]    mepc_q, mepc_d;
    logic [ADDR_WIDTH-1:0]    mcause_q, mcause_d;

    logic                     w_irq_valid;
    logic [4:0]               w_irq_cause;
    logic                     w_take;
    logic [ADDR_WIDTH-1:0]    w_vec_pc;
    logic                     w_unused;

    // mepc is word aligned, so the low PC bits are never stored
    assign w_unused = &{1'b0, pc_of_epc_in[1:0]};

    irq_prio_enc #(
        .NUM_EXT_IRQ (NUM_EXT_IRQ)
    ) u_prio_enc (
        .timer_pend_in (timer_irq_in & mtie_q),
        .ext_pend_in   (ext_irq_in & meie_q),
        .valid_out     (w_irq_valid),
        .cause_out     (w_irq_cause)
    );

    assign w_take = (state_q == ST_IDLE) && st_mie_q && w_irq_valid && !stall_in;

    // Next state: software CSR writes first, hardware trap/return updates override
    always_comb begin
        state_d   = state_q;
        st_mie_d  = st_mie_q;
        st_mpie_d = st_mpie_q;
        mtie_d    = mtie_q;
        meie_d    = meie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;

        if (csr_we_in) begin
            case (csr_addr_in)
                CSR_MSTATUS: begin
                    st_mie_d  = csr_wdata_in[MSTATUS_MIE_BIT];
                    st_mpie_d = csr_wdata_in[MSTATUS_MPIE_BIT];
                end
                CSR_MIE: begin
                    mtie_d = csr_wdata_in[MIE_MTIE_BIT];
                    meie_d = csr_wdata_in[MIE_MEIE_BASE +: NUM_EXT_IRQ];
                end
`ifdef INTERRUPT_VECTORED_EN
                CSR_MTVEC:  mtvec_d = csr_wdata_in;
`else
                CSR_MTVEC:  mtvec_d = {csr_wdata_in[ADDR_WIDTH-1:2], 2'b00};
`endif
                CSR_MEPC:   mepc_d   = {csr_wdata_in[ADDR_WIDTH-1:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata_in;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    state_d   = ST_TRAP;
                    mepc_d    = {pc_of_epc_in[ADDR_WIDTH-1:2], 2'b00};
                    mcause_d  = {1'b1, {(ADDR_WIDTH-6){1'b0}}, w_irq_cause};
                    st_mpie_d = st_mie_q;
                    st_mie_d  = 1'b0;
                end else if (mret_in) begin
                    state_d = ST_RET;
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            ST_RET: begin
                state_d   = ST_IDLE;
                st_mie_d  = st_mpie_q;
                st_mpie_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and CSR registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            st_mie_q  <= 1'b0;
            st_mpie_q <= 1'b0;
            mtie_q    <= 1'b0;
            meie_q    <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            state_q   <= state_d;
            st_mie_q  <= st_mie_d;
            st_mpie_q <= st_mpie_d;
            mtie_q    <= mtie_d;
            meie_q    <= meie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    // Trap vector from mtvec; vectored mode offsets by the latched cause
    always_comb begin
        w_vec_pc = {mtvec_q[ADDR_WIDTH-1:2], 2'b00};
`ifdef INTERRUPT_VECTORED_EN
        if (mtvec_q[1:0] == 2'b01) begin
            w_vec_pc = {mtvec_q[ADDR_WIDTH-1:2], 2'b00}
                     + (ADDR_WIDTH'(mcause_q[4:0]) << 2);
        end
`endif
    end

    // Redirect outputs decoded from the current state
    always_comb begin
        interrupt_en_out = 1'b0;
        isr_pc_out       = '0;
        case (state_q)
            ST_TRAP: begin
                interrupt_en_out = 1'b1;
                isr_pc_out       = w_vec_pc;
            end
            ST_RET: begin
                interrupt_en_out = 1'b1;
                isr_pc_out       = mepc_q;
            end
            default: ;
        endcase
    end

    // Combinational CSR read mux; unmapped addresses read 0
    always_comb begin
        csr_rdata_out = '0;
        case (csr_addr_in)
            CSR_MSTATUS: begin
                csr_rdata_out[MSTATUS_MIE_BIT]  = st_mie_q;
                csr_rdata_out[MSTATUS_MPIE_BIT] = st_mpie_q;
            end
            CSR_MIE: begin
                csr_rdata_out[MIE_MTIE_BIT]                  = mtie_q;
                csr_rdata_out[MIE_MEIE_BASE +: NUM_EXT_IRQ]  = meie_q;
            end
            CSR_MTVEC:  csr_rdata_out = mtvec_q;
            CSR_MEPC:   csr_rdata_out = mepc_q;
            CSR_MCAUSE: csr_rdata_out = mcause_q;
            CSR_MIP: begin
                csr_rdata_out[MIE_MTIE_BIT]                  = timer_irq_in;
                csr_rdata_out[MIE_MEIE_BASE +: NUM_EXT_IRQ]  = ext_irq_in;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_ctrl
// Description : Self-checking bench for interrupt_ctrl: directed scenarios
//               with literal expectations plus randomized traffic against a
//               behavioural CSR/redirect model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_ctrl;

    localparam int AW = 32;
    localparam int NE = 4;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          timer_irq_in;
    logic [NE-1:0] ext_irq_in;
    logic          stall_in;
    logic          mret_in;
    logic [AW-1:0] pc_of_epc_in;
    logic          csr_we_in;
    logic [11:0]   csr_addr_in;
    logic [AW-1:0] csr_wdata_in;
    logic [AW-1:0] csr_rdata_out;
    logic          interrupt_en_out;
    logic [AW-1:0] isr_pc_out;

    int errors = 0;
    int checks = 0;

    interrupt_ctrl #(.ADDR_WIDTH(AW), .NUM_EXT_IRQ(NE)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .timer_irq_in     (timer_irq_in),
        .ext_irq_in       (ext_irq_in),
        .stall_in         (stall_in),
        .mret_in          (mret_in),
        .pc_of_epc_in     (pc_of_epc_in),
        .csr_we_in        (csr_we_in),
        .csr_addr_in      (csr_addr_in),
        .csr_wdata_in     (csr_wdata_in),
        .csr_rdata_out    (csr_rdata_out),
        .interrupt_en_out (interrupt_en_out),
        .isr_pc_out       (isr_pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_kind: redirect the DUT must be showing this cycle (0 none, 1 trap, 2 return)
    bit            m_valid = 0;
    bit            m_mie_en, m_mpie;
    logic [AW-1:0] m_mie_reg, m_mtvec, m_mepc, m_mcause;
    int            m_kind;

    function automatic logic [AW-1:0] m_mip();
        return ({31'd0, timer_irq_in} << 7) | ({28'd0, ext_irq_in} << 16);
    endfunction

    function automatic logic [AW-1:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return ({31'd0, m_mie_en} << 3) | ({31'd0, m_mpie} << 7);
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
            default: return '0;
        endcase
    endfunction

    function automatic logic [AW-1:0] m_target();
        logic [AW-1:0] base;
        logic [AW-1:0] mode;
        base = m_mtvec & ~32'd3;
        mode = m_mtvec & 32'd3;
        if (m_kind == 2) return m_mepc;
`ifdef INTERRUPT_VECTORED_EN
        if (mode == 1) return base + 4 * (m_mcause % 32);
`endif
        return base;
    endfunction

    always @(posedge clk_in) begin
        logic [AW-1:0] pend;
        bit            take;
        int            prev, cause;
        if (!reset_in) begin
            m_valid = 1;
            m_mie_en = 0; m_mpie = 0;
            m_mie_reg = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
            m_kind = 0;
        end else if (m_valid) begin
            pend  = m_mip() & m_mie_reg;
            take  = (m_kind == 0) && m_mie_en && (pend != 0) && !stall_in;
            prev  = m_kind;
            cause = 0;
            if (pend[7]) cause = 7;
            else for (int i = NE - 1; i >= 0; i--) if (pend[16+i]) cause = 16 + i;
            if (csr_we_in) begin
                if (csr_addr_in == 12'h300 && !take && prev != 2) begin
                    m_mie_en = csr_wdata_in[3];
                    m_mpie   = csr_wdata_in[7];
                end
                if (csr_addr_in == 12'h304) m_mie_reg = csr_wdata_in & 32'h000F_0080;
`ifdef INTERRUPT_VECTORED_EN
                if (csr_addr_in == 12'h305) m_mtvec = csr_wdata_in;
`else
                if (csr_addr_in == 12'h305) m_mtvec = csr_wdata_in & ~32'd3;
`endif
                if (csr_addr_in == 12'h341 && !take) m_mepc = csr_wdata_in & ~32'd3;
                if (csr_addr_in == 12'h342 && !take) m_mcause = csr_wdata_in;
            end
            if (take) begin
                m_mepc   = pc_of_epc_in & ~32'd3;
                m_mcause = 32'h8000_0000 + cause;
                m_mpie   = m_mie_en;
                m_mie_en = 0;
                m_kind   = 1;
            end else if (prev == 0 && mret_in) begin
                m_kind = 2;
            end else begin
                m_kind = 0;
            end
            if (prev == 2) begin
                m_mie_en = m_mpie;
                m_mpie   = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk_in) begin
        if (m_valid && reset_in) begin
            chk("redirect_en", {31'd0, interrupt_en_out}, {31'd0, m_kind != 0});
            chk("isr_pc", isr_pc_out, (m_kind != 0) ? m_target() : '0);
            chk("csr_rdata", csr_rdata_out, m_read(csr_addr_in));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [AW-1:0] exp);
        csr_addr_in = a;
        #1;
        chk(name, csr_rdata_out, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [AW-1:0] d);
        csr_we_in = 1; csr_addr_in = a; csr_wdata_in = d;
        tick();
        csr_we_in = 0;
    endtask

    task automatic do_mret();
        mret_in = 1;
        tick();
        mret_in = 0;
        tick();
    endtask

    logic [11:0] addr_tab [8];
    logic [AW-1:0] exp_vec;

    initial begin
        addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7FF, 12'h300};
        reset_in = 0; timer_irq_in = 0; ext_irq_in = 0; stall_in = 0; mret_in = 0;
        pc_of_epc_in = 0; csr_we_in = 0; csr_addr_in = 0; csr_wdata_in = 0;
        repeat (3) tick();
        reset_in = 1;

        // Reset state
        foreach (addr_tab[i]) rd("reset_csr", addr_tab[i], '0);
        chk("reset_en", {31'd0, interrupt_en_out}, 0);
        chk("reset_pc", isr_pc_out, 0);

        // Timer trap
        wr(12'h305, 32'h100);
        wr(12'h304, 32'h000F_0080);
        wr(12'h300, 32'h8);
        pc_of_epc_in = 32'h24; timer_irq_in = 1;
        tick();
        chk("trap_en", {31'd0, interrupt_en_out}, 1);
        chk("trap_pc", isr_pc_out, 32'h100);
        timer_irq_in = 0;
        tick();
        chk("trap_one_cycle", {31'd0, interrupt_en_out}, 0);
        rd("trap_mepc", 12'h341, 32'h24);
        rd("trap_mcause", 12'h342, 32'h8000_0007);
        rd("trap_mstatus", 12'h300, 32'h80);

        // mret
        mret_in = 1;
        tick();
        mret_in = 0;
        chk("ret_en", {31'd0, interrupt_en_out}, 1);
        chk("ret_pc", isr_pc_out, 32'h24);
        tick();
        rd("ret_mstatus", 12'h300, 32'h88);

        // Timer and external together; then external re-taken after mret
        ext_irq_in = 4'b0110; timer_irq_in = 1; pc_of_epc_in = 32'h40;
        tick();
        rd("prio_timer", 12'h342, 32'h8000_0007);
        timer_irq_in = 0;
        tick();
        mret_in = 1;
        tick();
        mret_in = 0;
        chk("ret2_pc", isr_pc_out, 32'h40);
        tick();
        chk("ret2_gap", {31'd0, interrupt_en_out}, 0);
        tick();
        chk("ext_en", {31'd0, interrupt_en_out}, 1);
        rd("ext_cause", 12'h342, 32'h8000_0011);
        ext_irq_in = 0;
        tick();
        do_mret();

        // Stall defers trap entry
        stall_in = 1; timer_irq_in = 1;
        repeat (3) begin
            tick();
            chk("stall_hold", {31'd0, interrupt_en_out}, 0);
        end
        stall_in = 0;
        tick();
        chk("stall_release", {31'd0, interrupt_en_out}, 1);
        timer_irq_in = 0;
        tick();
        do_mret();

        // Vectored mode request
        wr(12'h305, 32'h101);
        ext_irq_in = 4'b0001;
        tick();
`ifdef INTERRUPT_VECTORED_EN
        exp_vec = 32'h140;
`else
        exp_vec = 32'h100;
`endif
        chk("vec_pc", isr_pc_out, exp_vec);
        ext_irq_in = 0;
        tick();
        do_mret();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset_in     = ($urandom_range(0, 299) != 0);
            timer_irq_in = ($urandom_range(0, 5) == 0);
            ext_irq_in   = ($urandom_range(0, 2) == 0) ? NE'($urandom) : '0;
            stall_in     = ($urandom_range(0, 3) == 0);
            mret_in      = ($urandom_range(0, 5) == 0);
            pc_of_epc_in = $urandom;
            csr_we_in    = ($urandom_range(0, 3) == 0);
            csr_addr_in  = addr_tab[$urandom_range(0, 7)];
            csr_wdata_in = $urandom;
            if ($urandom_range(0, 1) == 0) csr_wdata_in[3] = 1'b1;
            if (csr_addr_in == 12'h304 && $urandom_range(0, 1) == 0) csr_wdata_in = 32'h000F_0080;
            if (csr_addr_in == 12'h305 && $urandom_range(0, 1) == 0) csr_wdata_in[1:0] = 2'b01;
            tick();
        end

        reset_in = 1; csr_we_in = 0; mret_in = 0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Machine-mode interrupt controller feeding the pipeline controller. It samples timer and external interrupt lines and holds the machine CSRs (mstatus, mie, mip, mtvec, mepc, mcause). On a trap entry or `mret` it raises a one-cycle redirect request with the target PC. It captures the interrupted PC from the pipeline controller's `pc_of_epc` into mepc and serves CSR reads and writes from the execute stage.

## Interface
- `ADDR_WIDTH`, default 32: PC and CSR data width.
- `NUM_EXT_IRQ`, default 4: number of external interrupt lines, 1..16.

- `clk_in`  in  1: clock.
- `reset_in`  in  1: synchronous, active-low reset.
- `timer_irq_in`  in  1: level timer interrupt.
- `ext_irq_in`  in  NUM_EXT_IRQ: level external interrupts.
- `stall_in`  in  1: pipeline stalled; trap entry is deferred while high.
- `mret_in`  in  1: `mret` retiring in execute, 1-cycle pulse.
- `pc_of_epc_in`  in  ADDR_WIDTH: PC to save as mepc.
- `csr_we_in`  in  1: CSR write strobe.
- `csr_addr_in`  in  12: CSR address, shared by read and write.
- `csr_wdata_in`  in  ADDR_WIDTH: CSR write data.
- `csr_rdata_out`  out  ADDR_WIDTH: combinational CSR read data; 0 for an unmapped address.
- `interrupt_en_out`  out  1: redirect/flush request, 1-cycle pulse.
- `isr_pc_out`  out  ADDR_WIDTH: redirect target, valid while `interrupt_en_out` is high.

## Operation
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE; other bits read 0.
  - mie 0x304: bit7 MTIE, bits 16+i MEIE[i].
  - mtvec 0x305.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only; bit7 = timer_irq_in, bits 16+i = ext_irq_in[i].
- Pending-enabled vector = mip & mie. An interrupt is taken when MIE=1, the vector is nonzero and stall_in=0.
- Priority: timer (cause 7) beats external. Among external lines, the lowest index wins (cause 16+i).
- FSM states: IDLE, TRAP, RET.
  - IDLE→TRAP when the take condition holds.
    - On that edge: mepc<=pc_of_epc_in, mcause<={1'b1, cause}, MPIE<=MIE, MIE<=0.
  - IDLE→RET when mret_in=1 and no interrupt is taken.
  - TRAP→IDLE and RET→IDLE unconditionally.
    - Leaving RET also sets MIE<=MPIE and MPIE<=1.
- Output per state:
  - TRAP: interrupt_en_out=1, isr_pc_out = trap vector.
  - RET: interrupt_en_out=1, isr_pc_out = mepc.
  - IDLE: both outputs 0.
- Direct vector = {mtvec[ADDR_WIDTH-1:2], 2'b00}.
- Simultaneous events:
  - Interrupt take and mret_in in the same cycle: the interrupt wins and mret_in is dropped. Upstream flush makes the `mret` re-execute.
  - CSR write in the same cycle as a TRAP entry or RET exit: hardware updates of mepc, mcause and mstatus win; writes to other CSRs proceed.
  - mret_in in TRAP or RET: ignored.
- Reset (any state, mid-operation): FSM→IDLE; all CSRs 0; interrupt_en_out=0; isr_pc_out=0.

## Timing
- Take condition sampled at edge N; interrupt_en_out high for exactly cycle N+1.
- mret_in at edge N; redirect in cycle N+1. MIE restored at edge N+1, so an interrupt can next be taken at edge N+2 at the earliest.
- Minimum spacing between two redirect pulses: 2 cycles.
- A CSR write is visible on csr_rdata_out in the cycle after the write edge.
- An mie/mstatus write enabling an interrupt takes effect from the following edge.
- stall_in high holds the FSM in IDLE; irq lines remain level-sampled.

## Configuration
- `INTERRUPT_VECTORED_EN` defined: when mtvec[1:0]==2'b01, the interrupt vector = base + 4*cause[4:0]. Any other mode value selects the direct vector.
- `INTERRUPT_VECTORED_EN` undefined: always the direct vector; mtvec[1:0] read back as 0.

## Structure
- Shared defines header holds:
  - CSR addresses (`CSR_MSTATUS` … `CSR_MIP`).
  - Cause codes (`CAUSE_MTI`=7, `CAUSE_MEI_BASE`=16).
  - mstatus bit positions.
  - State encodings IDLE=2'd0, TRAP=2'd1, RET=2'd2.
  - Existing `ADDR_WIDTH` and `ZERO`.
- Sub-module `irq_prio_enc`: combinational priority encoder from mip&mie to {valid, cause[4:0]}.

## Test plan
- Reset, then read every CSR and outputs → all 0.
- Write mtvec=0x100, mie bit7, mstatus MIE=1; pulse timer_irq_in with pc_of_epc_in=0x24 → one-cycle interrupt_en_out, isr_pc_out=0x100, mepc=0x24, mcause=0x80000007, MIE=0, MPIE=1.
- Raise ext_irq_in=4'b0110 with all enabled → cause 17. Raise timer in the same cycle → cause 7 is taken first.
- Pending interrupt with stall_in=1 for 3 cycles → no pulse; pulse appears 1 cycle after stall_in falls.
- After a trap, pulse mret_in → isr_pc_out=mepc (0x24), MIE=1. Pending irq re-taken at the earliest 2 cycles after mret_in.
- With `INTERRUPT_VECTORED_EN`, mtvec=0x101, ext irq 0 → isr_pc_out=0x140. Without the macro, same stimulus → 0x100.
